// File: rtl/vend_change.sv
// rtl/vend_change.sv - change dispenser FSM, pays credit minus price as one-unit/half-unit coins via Ack handshake
// Optional per-coin Ack timeout: VEND_CHANGE_TIMEOUT_EN
module vend_change #(
    parameter int WIDTH   = 4,
    parameter int PRICE   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Credit,
    input  logic             Ack,
    output logic [1:0]       Out,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    localparam logic [WIDTH-1:0] PRICE_W = WIDTH'(PRICE);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_PAY1,
        S_PAY0,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] rem, rem_next;
    logic             timed_out;

`ifdef VEND_CHANGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;

    // Held at zero outside the pay states, so every coin starts a fresh count
    always_ff @(posedge Clk) begin
        if (!Reset || (state != S_PAY1 && state != S_PAY0)) begin
            tmo_cnt <= '0;
        end else if (!Ack) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timed_out = !Ack && (tmo_cnt == CW'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= S_IDLE;
            rem   <= '0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
        end
    end

    always_comb begin
        state_next = state;
        rem_next   = rem;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    if (Credit < PRICE_W) begin
                        state_next = S_ERR;
                    end else begin
                        rem_next   = Credit - PRICE_W;
                        state_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (rem == '0) begin
                    state_next = S_DONE;
                end else if (rem >= TWO) begin
                    state_next = S_PAY1;
                end else begin
                    state_next = S_PAY0;
                end
            end
            // Ack takes priority over a timeout landing on the same edge
            S_PAY1: begin
                if (Ack) begin
                    rem_next   = rem - TWO;
                    state_next = S_CHECK;
                end else if (timed_out) begin
                    state_next = S_ERR;
                end
            end
            S_PAY0: begin
                if (Ack) begin
                    rem_next   = rem - 1'b1;
                    state_next = S_CHECK;
                end else if (timed_out) begin
                    state_next = S_ERR;
                end
            end
            S_DONE: state_next = S_IDLE;
            S_ERR: begin
                rem_next   = '0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        Out  = 2'b00;
        Busy = (state != S_IDLE);
        Done = (state == S_DONE);
        Err  = (state == S_ERR);
        if (state == S_PAY1) begin
            Out = 2'b10;
        end else if (state == S_PAY0) begin
            Out = 2'b01;
        end
    end

endmodule
